stopwatch_datapath: RTL and testbench
=====================================

// Module: stopwatch_datapath
// PURPOSE
//  Stopwatch time base and counter chain: run/stop/clear FSM, a tick divider and cascaded
//  msec/sec/min/hour counters. Sits directly upstream of digit_splitter; each counter output
//  feeds one splitter instance, which feeds the BCD-to-FND decoder.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock frequency, Hz
//  TICK_HZ   100          counting rate, Hz (1 tick = 10 ms)
//  Derived: TICK_DIV = CLK_FREQ/TICK_HZ; divider width = $clog2(TICK_DIV)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high
//  btn_runstop in   1  debounced level; a rising edge toggles run/stop
//  btn_clear   in   1  debounced level; a rising edge requests clear
//  o_msec      out  7  hundredths of a second, 0..99
//  o_sec       out  6  seconds, 0..59
//  o_min       out  6  minutes, 0..59
//  o_hour      out  5  hours, 0..23
//  o_running   out  1  high while the FSM is in RUN
// BEHAVIOUR
//  Reset (async, active-high): state=STOP, divider=0, all counters=0, o_running=0, edge
//   registers=0. Every output is registered, so reset takes effect immediately.
//  Edge detect: both buttons are registered once. The event is btn & ~btn_q.
//   A level held high gives exactly one event. Event latency: 1 clk.
//  FSM states: STOP, RUN, CLEAR.
//   STOP : clear_evt -> CLEAR; else runstop_evt -> RUN; else stay. clear has priority.
//   RUN  : runstop_evt -> STOP; clear_evt is ignored (no effect, not queued).
//   CLEAR: lasts exactly one cycle. Zeroes the divider and all counters. Next state is
//          always STOP. Any event that arrives during CLEAR is ignored.
//  o_running = (state==RUN), registered with the state.
//  Divider: counts only in RUN. Wraps at TICK_DIV-1 and raises an internal tick on that
//   cycle. In STOP it holds its value, so stop/resume keeps sub-tick phase. It is cleared
//   only in CLEAR or by reset.
//  Counter chain: updates on the same edge on which the divider wraps.
//   msec increments each tick. At 99 it wraps to 0 and carries to sec.
//   sec wraps 59->0 and carries to min.
//   min wraps 59->0 and carries to hour.
//   hour wraps 23->0.
//   Full rollover: 23:59:59.99 -> 00:00:00.00 in one tick, with no intermediate values.
//  Timing: the first msec increment occurs TICK_DIV clk edges after the edge on which the
//   state enters RUN.
//  Counters never leave their legal ranges. No value above the maximum is ever output.
//  Widths: all compares are exact against constants. No arithmetic exceeds the port widths.
//  Reset mid-count: all counters and the state return to zero/STOP asynchronously. The
//   block resumes at STOP after reset deasserts.
// TESTING  (bench: CLK_FREQ=1000, TICK_HZ=100 -> TICK_DIV=10)
//  1. Reset, then a runstop pulse. After 10 clk in RUN, o_msec=1. After 1000 clk, o_msec=0,
//     o_sec=1, o_running=1.
//  2. Hold btn_runstop high for 50 clk. Exactly one toggle to RUN; o_running stays 1.
//  3. In RUN at divider=4: stop, wait 100 clk, then run. The next msec increment occurs 6 clk
//     after re-entering RUN, and values are held while stopped.
//  4. btn_clear in RUN -> no change. btn_clear in STOP -> all outputs 0 after 2 clk, then
//     state STOP. btn_runstop and btn_clear rising together in STOP -> CLEAR, not RUN.
//  5. Force 23:59:59.98 (run ~8.64M ticks, or run a hierarchical preload in sim) and run
//     2 ticks. Sequence .99, then 00:00:00.00.
//  6. Assert reset mid-RUN asynchronously, between edges. All outputs are 0 immediately;
//     after deassert, the block stays in STOP until the next runstop edge.

Source files
------------

// File: rtl/stopwatch_datapath.sv
// Stopwatch time base: run/stop/clear FSM, tick divider and cascaded
// msec/sec/min/hour counters feeding the digit splitters.
module stopwatch_datapath #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_runstop,
  input  logic       btn_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_running,
  output logic [1:0] o_state
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_running;
  logic             r_rs_q;
  logic             r_clr_q;
  logic [DIV_W-1:0] r_div;
  logic [6:0]       r_msec;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [4:0]       r_hour;

  logic w_rs_evt;
  logic w_clr_evt;
  logic w_tick;

  // One event per rising edge: the current level against last cycle's level.
  assign w_rs_evt  = btn_runstop & ~r_rs_q;
  assign w_clr_evt = btn_clear & ~r_clr_q;
  assign w_tick    = (r_state == ST_RUN) && (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs_q  <= 1'b0;
      r_clr_q <= 1'b0;
    end else begin
      r_rs_q  <= btn_runstop;
      r_clr_q <= btn_clear;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_STOP: begin
          if (w_clr_evt) begin
            r_state   <= ST_CLEAR;
            r_running <= 1'b0;
          end else if (w_rs_evt) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_rs_evt) begin
            r_state   <= ST_STOP;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_STOP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // The divider holds in STOP so a resumed run keeps its sub-tick phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_div <= '0;
    end else if (r_state == ST_RUN) begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msec <= 7'd0;
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 5'd0;
    end else if (r_state == ST_CLEAR) begin
      r_msec <= 7'd0;
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 5'd0;
    end else if (w_tick) begin
      if (r_msec == 7'd99) begin
        r_msec <= 7'd0;
        if (r_sec == 6'd59) begin
          r_sec <= 6'd0;
          if (r_min == 6'd59) begin
            r_min  <= 6'd0;
            r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        r_msec <= r_msec + 7'd1;
      end
    end
  end

  assign o_msec    = r_msec;
  assign o_sec     = r_sec;
  assign o_min     = r_min;
  assign o_hour    = r_hour;
  assign o_running = r_running;
  assign o_state   = r_state;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath with TICK_DIV = 10.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_stopwatch_datapath;

  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic       clk;
  logic       reset;
  logic       btn_runstop;
  logic       btn_clear;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_running;
  logic [1:0] o_state;

  int n_vec;
  int n_err;

  stopwatch_datapath #(
    .CLK_FREQ(1000),
    .TICK_HZ (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_runstop(btn_runstop),
    .btn_clear  (btn_clear),
    .o_msec     (o_msec),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_running  (o_running),
    .o_state    (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
    check({tag, ".hour"}, 32'(o_hour), 32'(h));
    check({tag, ".min"},  32'(o_min),  32'(m));
    check({tag, ".sec"},  32'(o_sec),  32'(s));
    check({tag, ".msec"}, 32'(o_msec), 32'(ms));
  endtask

  // Pulse held for one falling-to-falling window: sampled by exactly one rising edge.
  task automatic press_runstop();
    btn_runstop = 1'b1;
    @(negedge clk);
    btn_runstop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    btn_runstop = 1'b0;
    btn_clear   = 1'b0;
    idle(3);
    check_time("reset", 0, 0, 0, 0);
    check("reset.running", 32'(o_running), 32'd0);
    check("reset.state", 32'(o_state), 32'(S_STOP));
    reset = 1'b0;
    idle(2);
    check("idle.state", 32'(o_state), 32'(S_STOP));

    // 1: run from zero, first tick after 10 clk, first second after 1000 clk
    press_runstop();
    check("t1.running", 32'(o_running), 32'd1);
    check("t1.state", 32'(o_state), 32'(S_RUN));
    idle(9);
    check("t1.before_tick", 32'(o_msec), 32'd0);
    idle(1);
    check("t1.first_tick", 32'(o_msec), 32'd1);
    idle(990);
    check_time("t1.one_sec", 0, 0, 1, 0);
    check("t1.running_1s", 32'(o_running), 32'd1);
    idle(1);
    press_runstop();
    check("t1.stopped", 32'(o_running), 32'd0);
    btn_clear = 1'b1;
    idle(1);
    btn_clear = 1'b0;
    idle(1);
    check_time("t1.cleared", 0, 0, 0, 0);

    // 2: held button gives a single toggle
    btn_runstop = 1'b1;
    idle(25);
    check("t2.mid_hold", 32'(o_running), 32'd1);
    idle(25);
    check("t2.end_hold", 32'(o_running), 32'd1);
    check("t2.msec", 32'(o_msec), 32'd4);
    btn_runstop = 1'b0;
    idle(1);
    press_runstop();
    check("t2.stopped", 32'(o_state), 32'(S_STOP));
    btn_clear = 1'b1;
    idle(1);
    btn_clear = 1'b0;
    idle(1);
    check_time("t2.cleared", 0, 0, 0, 0);

    // 3: stop with divider at 4, resume, next tick 6 clk later
    press_runstop();
    idle(20);
    check("t3.msec_run", 32'(o_msec), 32'd2);
    idle(3);
    press_runstop();
    check("t3.stopped", 32'(o_running), 32'd0);
    idle(100);
    check("t3.held_msec", 32'(o_msec), 32'd2);
    check("t3.held_state", 32'(o_state), 32'(S_STOP));
    press_runstop();
    check("t3.resumed", 32'(o_running), 32'd1);
    idle(5);
    check("t3.no_tick_yet", 32'(o_msec), 32'd2);
    idle(1);
    check("t3.tick_6clk", 32'(o_msec), 32'd3);

    // 4: clear ignored in RUN, honoured in STOP, events during CLEAR dropped
    btn_clear = 1'b1;
    idle(1);
    btn_clear = 1'b0;
    check("t4.run_clear_state", 32'(o_state), 32'(S_RUN));
    check("t4.run_clear_msec", 32'(o_msec), 32'd3);
    idle(1);
    press_runstop();
    check("t4.stop", 32'(o_state), 32'(S_STOP));
    btn_clear = 1'b1;
    idle(1);
    check("t4.in_clear", 32'(o_state), 32'(S_CLEAR));
    check("t4.clear_msec_1clk", 32'(o_msec), 32'd3);
    btn_clear   = 1'b0;
    btn_runstop = 1'b1;
    idle(1);
    btn_runstop = 1'b0;
    check_time("t4.cleared", 0, 0, 0, 0);
    check("t4.after_clear", 32'(o_state), 32'(S_STOP));
    idle(3);
    check("t4.evt_dropped", 32'(o_running), 32'd0);
    btn_runstop = 1'b1;
    btn_clear   = 1'b1;
    idle(1);
    btn_runstop = 1'b0;
    btn_clear   = 1'b0;
    check("t4.both_state", 32'(o_state), 32'(S_CLEAR));
    check("t4.both_running", 32'(o_running), 32'd0);
    idle(1);
    check("t4.both_stop", 32'(o_state), 32'(S_STOP));

    // 5: full rollover from a preloaded 23:59:59.98
    dut.r_hour = 5'd23;
    dut.r_min  = 6'd59;
    dut.r_sec  = 6'd59;
    dut.r_msec = 7'd98;
    idle(1);
    check_time("t5.preload", 23, 59, 59, 98);
    press_runstop();
    idle(9);
    check("t5.pre_tick", 32'(o_msec), 32'd98);
    idle(1);
    check_time("t5.t99", 23, 59, 59, 99);
    idle(9);
    check("t5.pre_roll", 32'(o_msec), 32'd99);
    idle(1);
    check_time("t5.rollover", 0, 0, 0, 0);
    check("t5.running", 32'(o_running), 32'd1);

    // 6: asynchronous reset between edges while running
    idle(37);
    check("t6.counting", 32'(o_msec), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_time("t6.async", 0, 0, 0, 0);
    check("t6.async_running", 32'(o_running), 32'd0);
    check("t6.async_state", 32'(o_state), 32'(S_STOP));
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    check("t6.stays_stop", 32'(o_state), 32'(S_STOP));
    check("t6.no_count", 32'(o_msec), 32'd0);
    press_runstop();
    check("t6.restart", 32'(o_running), 32'd1);
    idle(10);
    check("t6.restart_tick", 32'(o_msec), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
